// File: rtl/friscv_rambe_ctrl_pkg.sv
// Shared constants and helpers for the byte-enable RAM request front end.
package friscv_rambe_ctrl_pkg;

    localparam int unsigned RAMBE_ADDR_W    = 8;
    localparam int unsigned RAMBE_DATA_W    = 32;
    localparam int unsigned RAMBE_RSP_DEPTH = 4;

    // Counter width able to hold the values 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/friscv_rambe_rspfifo.sv
// Synchronous response FIFO, registered count, first-word-fall-through output.
module friscv_rambe_rspfifo
    import friscv_rambe_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RAMBE_DATA_W,
    parameter int unsigned DEPTH      = RAMBE_RSP_DEPTH
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic                          pop_valid,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  empty;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    // Pop only real data; a push into a full FIFO is only taken alongside a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy tracking.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Data storage; contents need no reset since occupancy gates the output.
    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_valid = ~empty;
    assign pop_data  = empty ? '0 : mem[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/friscv_rambe_ctrl.sv
// Request front end for the byte-enable RAM: issue stage, RAM drive,
// credit-gated in-order read response path.
module friscv_rambe_ctrl
    import friscv_rambe_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RAMBE_ADDR_W,
    parameter int unsigned DATA_WIDTH = RAMBE_DATA_W,
    parameter int unsigned RSP_DEPTH  = RAMBE_RSP_DEPTH
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    busy,
    output logic                    ram_wr_en,
    output logic [DATA_WIDTH/8-1:0] ram_wr_be,
    output logic [ADDR_WIDTH-1:0]   ram_addr_in,
    output logic [DATA_WIDTH-1:0]   ram_data_in,
    output logic [ADDR_WIDTH-1:0]   ram_addr_out,
    input  logic [DATA_WIDTH-1:0]   ram_data_out
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = cnt_width(RSP_DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_W-1:0]       be;
    } req_t;

    req_t             req_in;
    req_t             iss_q;
    logic             iss_valid;
    logic             rd_pend;
    logic             ready_en;
    logic             accept;
    logic [CNT_W-1:0] fifo_count;
    logic [SUM_W-1:0] credit_used;

    assign req_in = {req_wr, req_addr, req_wdata, req_be};

    // Every read in the issue or RAM stage holds a FIFO slot in reserve, so
    // pushed data always has room even while the consumer stalls.
    assign credit_used = SUM_W'(iss_valid & ~iss_q.wr) + SUM_W'(rd_pend)
                       + SUM_W'(fifo_count);
    assign req_ready   = ready_en & (credit_used < SUM_W'(RSP_DEPTH));
    assign accept      = req_valid & req_ready;

    // Issue stage and RAM-stage read tracking; in-flight reads die on reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en  <= 1'b0;
            iss_valid <= 1'b0;
            iss_q     <= '0;
            rd_pend   <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            iss_valid <= accept;
            if (accept) iss_q <= req_in;
            rd_pend   <= iss_valid & ~iss_q.wr;
        end
    end

    assign ram_wr_en    = iss_valid & iss_q.wr;
    assign ram_wr_be    = iss_q.be;
    assign ram_addr_in  = iss_q.addr;
    assign ram_addr_out = iss_q.addr;
    assign ram_data_in  = iss_q.wdata;

    friscv_rambe_rspfifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_rspfifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (rd_pend),
        .push_data (ram_data_out),
        .pop       (rsp_ready),
        .pop_valid (rsp_valid),
        .pop_data  (rsp_rdata),
        .count     (fifo_count)
    );

    assign busy = iss_valid | rd_pend | (fifo_count != '0);

endmodule

// File: tb/tb_friscv_rambe_ctrl.sv
// Directed bench for friscv_rambe_ctrl with a registered-output byte-enable RAM model.
module tb_friscv_rambe_ctrl;

    logic        aclk;
    logic        aresetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        ram_wr_en;
    logic [3:0]  ram_wr_be;
    logic [7:0]  ram_addr_in;
    logic [31:0] ram_data_in;
    logic [7:0]  ram_addr_out;
    logic [31:0] ram_data_out;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    logic [31:0] rsp_q [$];
    int          rsp_t [$];
    logic [31:0] ram [256];

    friscv_rambe_ctrl #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .RSP_DEPTH  (4)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_be       (req_be),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_be    (ram_wr_be),
        .ram_addr_in  (ram_addr_in),
        .ram_data_in  (ram_data_in),
        .ram_addr_out (ram_addr_out),
        .ram_data_out (ram_data_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // RAM model: byte-lane writes, registered read output, no reset.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram_data_out = 32'h0;
    end
    always @(posedge aclk) begin
        if (ram_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wr_be[b]) ram[ram_addr_in][8*b +: 8] <= ram_data_in[8*b +: 8];
        end
        ram_data_out <= ram[ram_addr_out];
    end

    // Response monitor: logs each beat that the coming edge will pop.
    always @(negedge aclk) begin
        if (aresetn && rsp_valid && rsp_ready) begin
            rsp_q.push_back(rsp_rdata);
            rsp_t.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pat(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    function automatic logic [31:0] get_rsp(input int i);
        if (i < rsp_q.size()) return rsp_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_rsp();
        rsp_q.delete();
        rsp_t.delete();
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        logic done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        for (int k = 0; k < 64 && !done; k++) begin
            if (req_ready) done = 1'b1;
            step();
        end
        req_valid = 1'b0;
        check("issue_accept", 32'(done), 32'h1);
    endtask

    task automatic wait_rsp(input int n);
        for (int k = 0; k < 100 && rsp_q.size() < n; k++) step();
        check("wait_rsp", 32'(rsp_q.size()), 32'(n));
    endtask

    initial begin
        int  n;
        logic flag;

        aresetn   = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 8'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        rsp_ready = 1'b1;

        // Reset state.
        repeat (3) step();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ram_wr_en", 32'(ram_wr_en), 32'h0);
        check("rst_ram_addr_out", 32'(ram_addr_out), 32'h0);
        check("rst_ram_data_in", ram_data_in, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        aresetn = 1'b1;
        step();
        check("post_rst_req_ready", 32'(req_ready), 32'h1);

        // Full write, partial write, read back with latency check.
        clear_rsp();
        issue(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF);
        issue(1'b1, 8'h10, 32'h1122_3344, 4'b0101);
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        check("lat_t0_valid", 32'(rsp_valid), 32'h0);
        step();
        check("lat_t1_valid", 32'(rsp_valid), 32'h0);
        step();
        check("lat_t2_valid", 32'(rsp_valid), 32'h1);
        check("partial_write_data", rsp_rdata, 32'hDE22_BE44);
        step();
        check("popped_valid", 32'(rsp_valid), 32'h0);

        // Preload addresses 0..15, then 16 back-to-back reads.
        for (int i = 0; i < 16; i++) issue(1'b1, 8'(i), pat(i), 4'hF);
        repeat (2) step();
        clear_rsp();
        flag = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            req_wr    = 1'b0;
            req_addr  = 8'(i);
            if (!req_ready) flag = 1'b1;
            step();
        end
        req_valid = 1'b0;
        wait_rsp(16);
        check("b2b_ready_drop", 32'(flag), 32'h0);
        for (int i = 0; i < 16; i++) check($sformatf("b2b_data_%0d", i), get_rsp(i), pat(i));
        if (rsp_t.size() == 16) check("b2b_consecutive", 32'(rsp_t[15] - rsp_t[0]), 32'd15);
        else check("b2b_count", 32'(rsp_t.size()), 32'd16);

        // Backpressure: exactly RSP_DEPTH reads taken, then release.
        clear_rsp();
        rsp_ready = 1'b0;
        n = 0;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        for (int k = 0; k < 10; k++) begin
            req_addr = 8'(n);
            if (req_ready) n++;
            step();
        end
        req_valid = 1'b0;
        check("bp_accepted", 32'(n), 32'd4);
        check("bp_req_ready", 32'(req_ready), 32'h0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        check("bp_rsp_hold", rsp_rdata, pat(0));
        step();
        check("bp_rsp_stable", rsp_rdata, pat(0));
        rsp_ready = 1'b1;
        wait_rsp(4);
        for (int i = 0; i < 4; i++) check($sformatf("bp_data_%0d", i), get_rsp(i), pat(i));
        step();
        check("bp_resume_ready", 32'(req_ready), 32'h1);

        // Write then read next cycle; zero byte-enable write is a no-op.
        clear_rsp();
        issue(1'b1, 8'h20, 32'hA5A5_A5A5, 4'hF);
        issue(1'b0, 8'h20, 32'h0, 4'h0);
        issue(1'b1, 8'h20, 32'hFFFF_FFFF, 4'h0);
        issue(1'b0, 8'h20, 32'h0, 4'h0);
        wait_rsp(2);
        check("raw_next_cycle", get_rsp(0), 32'hA5A5_A5A5);
        check("be_zero_noop", get_rsp(1), 32'hA5A5_A5A5);

        // Writes alone never stall, even with the consumer stopped.
        rsp_ready = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_wr    = 1'b1;
            req_addr  = 8'h40 + 8'(i);
            req_wdata = 32'h0;
            req_be    = 4'hF;
            if (!req_ready) flag = 1'b1;
            step();
        end
        req_valid = 1'b0;
        check("wr_only_no_stall", 32'(flag), 32'h0);

        // Full FIFO stalls writes; they then commit in order.
        clear_rsp();
        for (int i = 0; i < 4; i++) issue(1'b0, 8'(i), 32'h0, 4'h0);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 8'h30;
        req_wdata = 32'hAAAA_0001;
        req_be    = 4'hF;
        flag = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (ram_wr_en) flag = 1'b1;
        end
        check("full_wr_stall_ready", 32'(req_ready), 32'h0);
        check("full_wr_no_commit", 32'(flag), 32'h0);
        rsp_ready = 1'b1;
        issue(1'b1, 8'h30, 32'hAAAA_0001, 4'hF);
        issue(1'b1, 8'h31, 32'hBBBB_0002, 4'hF);
        issue(1'b1, 8'h30, 32'hCCCC_0003, 4'h3);
        wait_rsp(4);
        for (int i = 0; i < 4; i++) check($sformatf("full_data_%0d", i), get_rsp(i), pat(i));
        issue(1'b0, 8'h30, 32'h0, 4'h0);
        issue(1'b0, 8'h31, 32'h0, 4'h0);
        wait_rsp(6);
        check("wr_order_0x30", get_rsp(4), 32'hAAAA_0003);
        check("wr_order_0x31", get_rsp(5), 32'hBBBB_0002);

        // Reset with two reads in flight and two in the FIFO.
        step();
        clear_rsp();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b0, 8'(i), 32'h0, 4'h0);
        check("pre_rst_busy", 32'(busy), 32'h1);
        check("pre_rst_valid", 32'(rsp_valid), 32'h1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        repeat (2) step();
        aresetn   = 1'b1;
        rsp_ready = 1'b1;
        repeat (5) step();
        check("post_rst_no_rsp", 32'(rsp_q.size()), 32'h0);
        check("post_rst_valid", 32'(rsp_valid), 32'h0);
        issue(1'b0, 8'h02, 32'h0, 4'h0);
        wait_rsp(1);
        check("post_rst_ram_intact", get_rsp(0), pat(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
